// File: rtl/piece_blit_engine.sv
// Sequential piece blitter: owns the locked playfield and runs CHECK/LOCK/ERASE/CLEAR
// one board column per cycle, with a registered column read port and live-piece overlay.
// state | meaning
// IDLE  | waiting for start
// RUN   | stepping k across piece (or board) columns
// DONE  | one-cycle done pulse, flags valid
module piece_blit_engine #(
  parameter int BOARD_W     = 10,
  parameter int BOARD_H     = 20,
  parameter int PIECE_N     = 4,
  parameter int COORD_W     = 6,
  parameter int ALLOW_ABOVE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [PIECE_N*PIECE_N-1:0]   piece,
  input  logic signed [COORD_W-1:0]    pos_x,
  input  logic signed [COORD_W-1:0]    pos_y,
  output logic                         busy,
  output logic                         done,
  output logic                         collide,
  output logic                         oob,
  input  logic [$clog2(BOARD_W)-1:0]   rd_col,
  input  logic                         rd_ovl,
  input  logic [PIECE_N*PIECE_N-1:0]   ov_piece,
  input  logic signed [COORD_W-1:0]    ov_x,
  input  logic signed [COORD_W-1:0]    ov_y,
  output logic [BOARD_H-1:0]           rd_data
);

  localparam int CW = $clog2(BOARD_W);
  localparam int KW = $clog2(BOARD_W > PIECE_N ? BOARD_W : PIECE_N);
  localparam logic [1:0] M_CHECK = 2'd0, M_LOCK = 2'd1, M_ERASE = 2'd2, M_CLEAR = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                       state, state_nx;
  logic [KW-1:0]                k;
  logic [1:0]                   lat_mode;
  logic [PIECE_N*PIECE_N-1:0]   lat_piece;
  logic signed [COORD_W-1:0]    lat_x, lat_y;
  logic [BOARD_H-1:0]           board [BOARD_W];

  logic                         last, in_x, hit, oob_hit, wr_en;
  int                           bx, dxo;
  logic [PIECE_N-1:0]           pcol;
  logic [BOARD_H-1:0]           m, cur, wr_val, rd_base, ovm, rd_next;
  logic [CW-1:0]                wr_idx;

  // Row mask of a piece column placed at origin row oy, clipped to the board.
  function automatic logic [BOARD_H-1:0] col_mask(input logic [PIECE_N-1:0] pc, input int oy);
    logic [BOARD_H-1:0] r;
    r = '0;
    for (int dy = 0; dy < PIECE_N; dy++)
      if (pc[dy] && (oy + dy >= 0) && (oy + dy < BOARD_H)) r[oy+dy] = 1'b1;
    return r;
  endfunction

  function automatic logic col_oob_y(input logic [PIECE_N-1:0] pc, input int oy);
    logic r;
    r = 1'b0;
    for (int dy = 0; dy < PIECE_N; dy++)
      if (pc[dy] && ((oy + dy >= BOARD_H) || (ALLOW_ABOVE == 0 && oy + dy < 0))) r = 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    last     = (k == ((lat_mode == M_CLEAR) ? KW'(BOARD_W - 1) : KW'(PIECE_N - 1)));
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      default: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bx      = 0;
    in_x    = 1'b0;
    pcol    = '0;
    m       = '0;
    cur     = '0;
    hit     = 1'b0;
    oob_hit = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_val  = '0;
    if (state == S_RUN) begin
      bx   = int'(lat_x) + int'(k);
      in_x = (bx >= 0) && (bx < BOARD_W);
      if (int'(k) < PIECE_N) pcol = lat_piece[int'(k)*PIECE_N +: PIECE_N];
      m      = col_mask(pcol, int'(lat_y));
      wr_idx = CW'(bx);
      cur    = board[wr_idx];
      case (lat_mode)
        M_CHECK, M_LOCK: begin
          hit     = in_x && (|(cur & m));
          oob_hit = ((|pcol) && !in_x) || col_oob_y(pcol, int'(lat_y));
          if (lat_mode == M_LOCK) begin
            wr_en  = in_x;
            wr_val = cur | m;
          end
        end
        M_ERASE: begin
          wr_en  = in_x;
          wr_val = cur & ~m;
        end
        default: begin
          wr_en  = 1'b1;
          wr_idx = CW'(k);
          wr_val = '0;
        end
      endcase
    end
  end

  // Read port forwards the column being written this cycle (write-first).
  always_comb begin
    rd_base = '0;
    ovm     = '0;
    rd_next = '0;
    dxo     = int'(rd_col) - int'(ov_x);
    if (int'(rd_col) < BOARD_W) begin
      rd_base = (wr_en && wr_idx == rd_col) ? wr_val : board[rd_col];
      if (rd_ovl && dxo >= 0 && dxo < PIECE_N)
        ovm = col_mask(ov_piece[dxo*PIECE_N +: PIECE_N], int'(ov_y));
      rd_next = rd_base | ovm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      lat_mode  <= M_CHECK;
      lat_piece <= '0;
      lat_x     <= '0;
      lat_y     <= '0;
      collide   <= 1'b0;
      oob       <= 1'b0;
      rd_data   <= '0;
      for (int i = 0; i < BOARD_W; i++) board[i] <= '0;
    end else begin
      rd_data <= rd_next;
      if (state == S_IDLE && start) begin
        k         <= '0;
        lat_mode  <= mode;
        lat_piece <= piece;
        lat_x     <= pos_x;
        lat_y     <= pos_y;
        collide   <= 1'b0;
        oob       <= 1'b0;
      end
      if (state == S_RUN) begin
        k       <= k + 1'b1;
        collide <= collide | hit;
        oob     <= oob | oob_hit;
        if (wr_en) board[wr_idx] <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_piece_blit_engine.sv
// Directed bench for piece_blit_engine: one task per scenario with hand-computed expectations.
module tb_piece_blit_engine;
  logic              clk = 1'b0;
  logic              reset, start, rd_ovl;
  logic [1:0]        mode;
  logic [15:0]       piece, ov_piece;
  logic signed [5:0] pos_x, pos_y, ov_x, ov_y;
  logic [3:0]        rd_col;
  logic              busy, done, collide, oob;
  logic [19:0]       rd_data;

  int passed = 0;
  int total  = 0;

  localparam logic [15:0] T_PC = 16'h0232;
  localparam logic [15:0] I_V  = 16'h000F;
  localparam logic [15:0] I_H  = 16'h1111;

  piece_blit_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .piece(piece),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done), .collide(collide), .oob(oob),
    .rd_col(rd_col), .rd_ovl(rd_ovl), .ov_piece(ov_piece), .ov_x(ov_x), .ov_y(ov_y),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic run_cmd(input logic [1:0] md, input logic [15:0] pc, input int x, input int y,
                         output int lat);
    @(negedge clk);
    mode = md; piece = pc; pos_x = 6'(x); pos_y = 6'(y); start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic rd(input int col, input logic ovl, output logic [19:0] d);
    @(negedge clk);
    rd_col = 4'(col); rd_ovl = ovl;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset();
    logic [19:0] d;
    for (int c = 0; c < 10; c++) begin
      rd(c, 1'b0, d);
      total++; if (d !== 20'h0) $display("FAIL reset_col%0d got %h want 0", c, d); else passed++;
      total++; if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL reset_ctl%0d got busy=%b done=%b want 0 0", c, busy, done); else passed++;
    end
  endtask

  task automatic test_lock_t();
    int lat; logic [19:0] d;
    logic [19:0] exp_col [6] = '{20'h0, 20'h0, 20'h0, 20'h2, 20'h3, 20'h2};
    run_cmd(2'd1, T_PC, 3, 0, lat);
    total++; if (lat !== 5) $display("FAIL lock_latency got %0d want 5", lat); else passed++;
    total++; if (collide !== 1'b0 || oob !== 1'b0)
      $display("FAIL lock_flags got %b%b want 00", collide, oob); else passed++;
    for (int c = 2; c < 7; c++) begin
      rd(c, 1'b0, d);
      total++;
      if (d !== ((c < 6) ? exp_col[c] : 20'h0)) $display("FAIL lock_col%0d got %h", c, d);
      else passed++;
    end
  endtask

  task automatic test_check_erase();
    int lat; logic [19:0] d;
    run_cmd(2'd0, T_PC, 3, 1, lat);
    total++; if (lat !== 5) $display("FAIL check_latency got %0d want 5", lat); else passed++;
    total++; if (collide !== 1'b1 || oob !== 1'b0)
      $display("FAIL check_flags got %b%b want 10", collide, oob); else passed++;
    rd(4, 1'b0, d);
    total++; if (d !== 20'h3) $display("FAIL check_unchanged got %h want 3", d); else passed++;
    run_cmd(2'd2, T_PC, 3, 0, lat);
    total++; if (collide !== 1'b0 || oob !== 1'b0)
      $display("FAIL erase_flags got %b%b want 00", collide, oob); else passed++;
    for (int c = 3; c < 6; c++) begin
      rd(c, 1'b0, d);
      total++; if (d !== 20'h0) $display("FAIL erase_col%0d got %h want 0", c, d); else passed++;
    end
  endtask

  task automatic test_oob();
    int lat;
    run_cmd(2'd0, I_V, -1, 0, lat);
    total++; if (oob !== 1'b1) $display("FAIL oob_left got %b want 1", oob); else passed++;
    run_cmd(2'd0, I_V, 0, 18, lat);
    total++; if (oob !== 1'b1) $display("FAIL oob_bottom got %b want 1", oob); else passed++;
    run_cmd(2'd0, I_V, 0, -2, lat);
    total++; if (oob !== 1'b0 || collide !== 1'b0)
      $display("FAIL oob_above got %b%b want 00", oob, collide); else passed++;
    run_cmd(2'd0, I_V, 9, 16, lat);
    total++; if (oob !== 1'b0) $display("FAIL oob_corner got %b want 0", oob); else passed++;
    run_cmd(2'd0, I_H, 7, 0, lat);
    total++; if (oob !== 1'b1) $display("FAIL oob_right got %b want 1", oob); else passed++;
  endtask

  task automatic test_clear();
    int lat; logic [19:0] d;
    run_cmd(2'd1, T_PC, 0, 0, lat);
    run_cmd(2'd0, T_PC, 0, 0, lat);
    total++; if (collide !== 1'b1) $display("FAIL clear_pre_collide got %b want 1", collide); else passed++;
    run_cmd(2'd3, 16'h0, 0, 0, lat);
    total++; if (lat !== 11) $display("FAIL clear_latency got %0d want 11", lat); else passed++;
    total++; if (collide !== 1'b0) $display("FAIL clear_flags got %b want 0", collide); else passed++;
    rd(1, 1'b0, d);
    total++; if (d !== 20'h0) $display("FAIL clear_col1 got %h want 0", d); else passed++;
  endtask

  task automatic test_busy_ignore();
    int ndone = 0; int cyc = -1; logic [19:0] d;
    @(negedge clk);
    mode = 2'd1; piece = T_PC; pos_x = 6'sd0; pos_y = 6'sd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); mode = 2'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 4; i <= 20; i++) begin
      if (done) begin cyc = i - 1; break; end
      @(negedge clk);
      if (done) begin cyc = i; break; end
    end
    total++; if (cyc !== 5) $display("FAIL busy_done_cycle got %0d want 5", cyc); else passed++;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL done_start_ignored got busy=%b want 0", busy); else passed++;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++; if (ndone !== 0) $display("FAIL extra_done got %0d want 0", ndone); else passed++;
    rd(1, 1'b0, d);
    total++; if (d !== 20'h3) $display("FAIL busy_col1 got %h want 3", d); else passed++;
  endtask

  task automatic test_reset_abort();
    int ndone = 0; logic [19:0] d;
    @(negedge clk);
    mode = 2'd1; piece = T_PC; pos_x = 6'sd5; pos_y = 6'sd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++; if (ndone !== 0) $display("FAIL abort_done got %0d want 0", ndone); else passed++;
    for (int c = 0; c < 10; c++) begin
      rd(c, 1'b0, d);
      total++; if (d !== 20'h0) $display("FAIL abort_col%0d got %h want 0", c, d); else passed++;
    end
  endtask

  task automatic test_overlay();
    logic [19:0] d;
    ov_piece = I_V; ov_x = 6'sd9; ov_y = 6'sd16;
    rd(9, 1'b1, d);
    total++; if (d !== 20'hF0000) $display("FAIL ovl_col9 got %h want f0000", d); else passed++;
    rd(9, 1'b0, d);
    total++; if (d !== 20'h0) $display("FAIL ovl_off got %h want 0", d); else passed++;
    rd(8, 1'b1, d);
    total++; if (d !== 20'h0) $display("FAIL ovl_col8 got %h want 0", d); else passed++;
    rd(10, 1'b1, d);
    total++; if (d !== 20'h0) $display("FAIL ovl_col10 got %h want 0", d); else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; piece = '0;
    pos_x = '0; pos_y = '0; rd_col = '0; rd_ovl = 1'b0;
    ov_piece = '0; ov_x = '0; ov_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_lock_t();
    test_check_erase();
    test_oob();
    test_clear();
    test_busy_ignore();
    test_reset_abort();
    test_overlay();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
